// File: rtl/ser_feeder.sv
// Parallel-to-serial feeder: WIDTH-bit words in, one bit per clock out, with a
// one-word holding buffer so consecutive words stream without an idle bit.
module ser_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_full, hold_full_n;
  logic             accept;

  // Handshake: a word transfers on a rising edge where in_valid & in_ready;
  // in_ready depends only on hold occupancy, never on in_valid.
  assign in_ready = ~hold_full;
  assign accept   = in_valid & ~hold_full;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic out_end(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return v[WIDTH-1];
    else           return v[0];
  endfunction

  always_comb begin
    state_n     = state;
    sh_n        = sh;
    hold_n      = hold;
    cnt_n       = cnt;
    hold_full_n = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          sh_n    = in_data;
          cnt_n   = CNT_TOP;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          // Held word has priority; in_ready is low then, so accept is 0.
          if (hold_full) begin
            sh_n        = hold;
            hold_full_n = 1'b0;
            cnt_n       = CNT_TOP;
          end else if (accept) begin
            sh_n  = in_data;
            cnt_n = CNT_TOP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          sh_n  = shift_one(sh);
          cnt_n = cnt - CW'(1);
          if (accept) begin
            hold_n      = in_data;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with sh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      hold      <= hold_n;
      cnt       <= cnt_n;
      hold_full <= hold_full_n;
      out_bit   <= (state_n == SHIFT) & out_end(sh_n);
      out_valid <= (state_n == SHIFT);
      word_done <= (state_n == SHIFT) && (cnt_n == '0);
      busy      <= (state_n == SHIFT) | hold_full_n;
    end
  end

endmodule

// File: tb/tb_ser_feeder.sv
// Bench for ser_feeder: an MSB-first and an LSB-first instance share stimulus;
// accepted words become expected bit queues that a negedge monitor drains.
module tb_ser_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;

  logic m_in_ready, m_out_bit, m_out_valid, m_word_done, m_busy;
  logic l_in_ready, l_out_bit, l_out_valid, l_word_done, l_busy;

  // Each entry is {expected bit, last bit of word}.
  logic [1:0] qm[$];
  logic [1:0] ql[$];
  logic [1:0] em, el;

  int total = 0;
  int bad   = 0;

  ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .out_bit(m_out_bit), .out_valid(m_out_valid),
    .word_done(m_word_done), .busy(m_busy)
  );

  ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .out_bit(l_out_bit), .out_valid(l_out_valid),
    .word_done(l_word_done), .busy(l_busy)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic exp, input logic act);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back({d[W-1-i], (i == W-1)});
      ql.push_back({d[i], (i == W-1)});
    end
  endtask

  // Drivers: inputs change 1ns after negedge; acceptance sampled just before posedge
  task automatic step(input logic v, input logic [W-1:0] d, output logic fired);
    @(negedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    #2;
    fired = v && m_in_ready && rst_n;
    @(posedge clk);
    if (fired) push_word(d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic f;
    repeat (n) step(1'b0, '0, f);
  endtask

  task automatic send_word(input logic [W-1:0] d);
    logic f;
    f = 1'b0;
    for (int k = 0; k < 40 && !f; k++) step(1'b1, d, f);
    chk("accept_timeout", 1'b1, f);
  endtask

  task automatic check_reset();
    chk("rst_bit_m",   1'b0, m_out_bit);
    chk("rst_valid_m", 1'b0, m_out_valid);
    chk("rst_done_m",  1'b0, m_word_done);
    chk("rst_busy_m",  1'b0, m_busy);
    chk("rst_ready_m", 1'b1, m_in_ready);
    chk("rst_bit_l",   1'b0, l_out_bit);
    chk("rst_valid_l", 1'b0, l_out_valid);
    chk("rst_busy_l",  1'b0, l_busy);
    chk("rst_ready_l", 1'b1, l_in_ready);
  endtask

  // Scoreboard monitor: pending bits imply valid/busy; more than one word pending implies not ready
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid_m", qm.size() != 0, m_out_valid);
      chk("busy_m",  qm.size() != 0, m_busy);
      chk("ready_m", qm.size() <= W, m_in_ready);
      if (qm.size() != 0) begin
        em = qm.pop_front();
        chk("bit_m",  em[1], m_out_bit);
        chk("done_m", em[0], m_word_done);
      end else begin
        chk("bit_m",  1'b0, m_out_bit);
        chk("done_m", 1'b0, m_word_done);
      end
      chk("valid_l", ql.size() != 0, l_out_valid);
      chk("busy_l",  ql.size() != 0, l_busy);
      chk("ready_l", ql.size() <= W, l_in_ready);
      if (ql.size() != 0) begin
        el = ql.pop_front();
        chk("bit_l",  el[1], l_out_bit);
        chk("done_l", el[0], l_word_done);
      end else begin
        chk("bit_l",  1'b0, l_out_bit);
        chk("done_l", 1'b0, l_word_done);
      end
    end
  end

  initial begin
    logic         f;
    logic         pend;
    logic [W-1:0] pd;
    int           run;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    #1 rst_n = 1'b1;

    // Single word, then back-to-back pair, then three words under backpressure
    send_word(8'hF0);
    idle(10);
    send_word(8'hFF);
    send_word(8'h0F);
    idle(20);
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'h81);
    idle(30);
    send_word(8'h01);
    idle(12);

    // Reset during cycle 4 of 8'hFF with a second word held
    send_word(8'hFF);
    send_word(8'h55);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    qm.delete();
    ql.delete();
    #1 check_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    #1 rst_n = 1'b1;
    idle(15);

    // Four-ones detector view of 8'h78: fourth consecutive 1 lands in cycle 5
    send_word(8'h78);
    run = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      #2;
      run = m_out_bit ? run + 1 : 0;
      chk("det_z", (k == 5), (run == 4));
    end
    idle(5);

    // Random traffic; data held stable while valid and not yet accepted
    pend = 1'b0;
    pd   = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 2) != 0);
        pd   = W'($urandom);
      end
      step(pend, pd, f);
      if (f) pend = 1'b0;
    end
    idle(30);
    chk("drain_m", 1'b1, qm.size() == 0);
    chk("drain_l", 1'b1, ql.size() == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
